shift_id_stage: RTL
===================

SHIFT_ID_STAGE -- requirements
Module: shift_id_stage

Interface
REQ-001 Parameter CNT_W, default 16: width of the issued-shift counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  discard all buffered entries.
REQ-005 in_valid  input  1  instr/rs_data/rt_data valid this cycle.
REQ-006 in_ready  output  1  stage can accept an input this cycle.
REQ-007 instr  input  32  MIPS instruction word.
REQ-008 rs_data  input  32  register-file read of instr[25:21].
REQ-009 rt_data  input  32  register-file read of instr[20:16].
REQ-010 out_valid  output  1  shift operation presented to the shift unit.
REQ-011 out_ready  input  1  downstream accepts the presented operation.
REQ-012 dina  output  5  shift amount.
REQ-013 dinb  output  32  operand to shift.
REQ-014 left  output  1  logical left shift select.
REQ-015 right  output  1  logical right shift select; left=0 and right=0 means arithmetic right.
REQ-016 rd_addr  output  5  destination register, instr[15:11].
REQ-017 wr_en  output  1  result is written back.
REQ-018 shift_cnt  output  CNT_W  count of operations accepted by downstream.

Function
REQ-019 Shift ops decode only when instr[31:26]=0; funct instr[5:0] = 000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV.
REQ-020 SLL/SLLV: left=1, right=0. SRL/SRLV: left=0, right=1. SRA/SRAV: left=0, right=0.
REQ-021 dina = instr[10:6] for SLL/SRL/SRA; dina = rs_data[4:0] for SLLV/SRLV/SRAV.
REQ-022 dinb = rt_data, unmodified, for all six ops.
REQ-023 wr_en = 1 iff rd_addr != 0.
REQ-024 An input handshake (in_valid and in_ready) with a non-shift instr is consumed and dropped: no output entry, no counter change.
REQ-025 Storage is a 2-entry skid buffer: output register (OR) drives outputs; skid register (SR) holds one overflow entry.
REQ-026 in_ready = not SR-occupied, driven from a register with no combinational path from out_ready.
REQ-027 Accepted shift op goes to OR if OR is empty or being drained this cycle, else to SR.
REQ-028 When OR drains (out_valid and out_ready) and SR is occupied, SR moves to OR the same edge; a simultaneous new input goes to SR.
REQ-029 Latency: an accepted shift op appears at the outputs on the cycle after acceptance when OR is empty.
REQ-030 Outputs hold stable while out_valid=1 and out_ready=0.
REQ-031 Ordering is strictly first-in first-out; no entry is lost or duplicated.
REQ-032 shift_cnt increments by 1 on each output handshake and saturates at all-ones.
REQ-033 flush: next edge clears OR and SR valid bits and ignores that cycle's input; a handshake in the flush cycle does not count; shift_cnt is not cleared.
REQ-034 When out_valid=0, dina/dinb/rd_addr hold their last values and left, right, wr_en are 0.

Reset
REQ-035 On a rising edge with rst_n=0: out_valid=0, in_ready=1, both entries empty, dina=0, dinb=0, left=0, right=0, rd_addr=0, wr_en=0, shift_cnt=0.
REQ-036 Reset mid-operation discards buffered entries; rst_n overrides flush and all inputs.

Verification
REQ-037 SLL instr 0x00021100 (rt=2, rd=2, shamt=4), rt_data=0x0000000F, out_ready=1 -> next cycle out_valid=1, dina=4, dinb=0x0000000F, left=1, right=0, rd_addr=2, wr_en=1.
REQ-038 SRAV rs_data=0x00000024, rt_data=0x80000000 -> dina=4, left=0, right=0; a SRLV with the same operands -> right=1.
REQ-039 out_ready=0, three back-to-back shift ops -> two accepted, in_ready=0 from the third cycle; then out_ready=1 -> the ops emerge in order, in_ready returns to 1.
REQ-040 Non-shift instr 0x00221820 (ADD) with in_valid=1 -> consumed, out_valid stays 0, shift_cnt unchanged; SLL with rd=0 -> wr_en=0.
REQ-041 Both entries full, flush=1 -> next cycle out_valid=0, in_ready=1, shift_cnt unchanged; CNT_W=4 with 17 handshakes -> shift_cnt=15.
REQ-042 rst_n=0 with both entries full and shift_cnt=5 -> all REQ-035 values on the next cycle.

Source files
------------

// File: rtl/shift_id_stage_if.sv
// Handshake and operand bundle between the decode front end, shift_id_stage and the shift unit.
// The slave modport is the stage itself; the master modport is its environment.
interface shift_id_stage_if #(
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       dina;
    logic [31:0]      dinb;
    logic             left;
    logic             right;
    logic [4:0]       rd_addr;
    logic             wr_en;
    logic [CNT_W-1:0] shift_cnt;

    modport slave (
        input  flush, in_valid, instr, rs_data, rt_data, out_ready,
        output in_ready, out_valid, dina, dinb, left, right, rd_addr, wr_en, shift_cnt
    );

    modport master (
        output flush, in_valid, instr, rs_data, rt_data, out_ready,
        input  in_ready, out_valid, dina, dinb, left, right, rd_addr, wr_en, shift_cnt
    );
endinterface

// File: rtl/shift_id_stage.sv
// Decodes MIPS shift instructions into shift-unit controls behind a 2-entry skid buffer,
// and counts the operations handed to the shift unit.
module shift_id_stage #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_id_stage_if.slave   bus
);

    typedef struct packed {
        logic [4:0]  dina;
        logic [31:0] dinb;
        logic        left;
        logic        right;
        logic [4:0]  rd;
        logic        wr;
    } entry_t;

    entry_t           or_q, or_d, sr_q, sr_d, new_e;
    logic             or_v_q, or_v_d, sr_v_q, sr_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_shift, accept, store, drain;

    always_comb begin
        is_shift    = 1'b0;
        new_e       = '0;
        new_e.dinb  = bus.rt_data;
        new_e.rd    = bus.instr[15:11];
        new_e.wr    = (bus.instr[15:11] != 5'd0);
        new_e.dina  = bus.instr[10:6];
        if (bus.instr[31:26] == 6'd0) begin
            case (bus.instr[5:0])
                6'b000000: begin is_shift = 1'b1; new_e.left  = 1'b1; end
                6'b000010: begin is_shift = 1'b1; new_e.right = 1'b1; end
                6'b000011: begin is_shift = 1'b1; end
                6'b000100: begin is_shift = 1'b1; new_e.left  = 1'b1; new_e.dina = bus.rs_data[4:0]; end
                6'b000110: begin is_shift = 1'b1; new_e.right = 1'b1; new_e.dina = bus.rs_data[4:0]; end
                6'b000111: begin is_shift = 1'b1; new_e.dina = bus.rs_data[4:0]; end
                default:   is_shift = 1'b0;
            endcase
        end
    end

    // A flush cycle neither stores the incoming op nor counts a downstream handshake.
    assign accept = bus.in_valid && !sr_v_q;
    assign store  = accept && is_shift && !bus.flush;
    assign drain  = or_v_q && bus.out_ready && !bus.flush;

    always_comb begin
        or_d   = or_q;
        sr_d   = sr_q;
        or_v_d = or_v_q;
        sr_v_d = sr_v_q;
        cnt_d  = cnt_q;
        if (drain && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (bus.flush) begin
            or_v_d = 1'b0;
            sr_v_d = 1'b0;
        end else if (drain) begin
            if (sr_v_q) begin
                or_d   = sr_q;
                sr_v_d = store;
                if (store) begin
                    sr_d = new_e;
                end
            end else begin
                or_v_d = store;
                if (store) begin
                    or_d = new_e;
                end
            end
        end else if (store) begin
            if (!or_v_q) begin
                or_d   = new_e;
                or_v_d = 1'b1;
            end else begin
                sr_d   = new_e;
                sr_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_q   <= '0;
            sr_q   <= '0;
            or_v_q <= 1'b0;
            sr_v_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            or_q   <= or_d;
            sr_q   <= sr_d;
            or_v_q <= or_v_d;
            sr_v_q <= sr_v_d;
            cnt_q  <= cnt_d;
        end
    end

    // Operand fields persist when idle; only the control strobes are qualified by valid.
    assign bus.out_valid = or_v_q;
    assign bus.in_ready  = !sr_v_q;
    assign bus.dina      = or_q.dina;
    assign bus.dinb      = or_q.dinb;
    assign bus.rd_addr   = or_q.rd;
    assign bus.left      = or_q.left  && or_v_q;
    assign bus.right     = or_q.right && or_v_q;
    assign bus.wr_en     = or_q.wr    && or_v_q;
    assign bus.shift_cnt = cnt_q;

endmodule
